cdb_arbiter: RTL



---
 rtl/cdb_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Common-data-bus arbiter. Grants the single CDB to one
//                functional unit per cycle and drives the registered
//                broadcast (valid, tag, data). Round-robin by default;
//                define CDB_FIXED_PRIO_EN for lowest-index-wins priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int TW   = 3
) (
    input  logic                 clk1,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*TW-1:0]   req_tag,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      grant,
    output logic                 cdb_valid,
    output logic [TW-1:0]        cdb_tag,
    output logic [DW-1:0]        cdb_data
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   r_ptr;
    logic [NREQ-1:0] w_elig;
    logic [PW-1:0]   w_start;
    logic [PW-1:0]   w_win;
    logic            w_found;
    logic [PW-1:0]   w_ptr_nxt;
    logic [NREQ-1:0] w_onehot;

    // Index (base + off) mod NREQ; base and off are both below NREQ.
    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
        logic [PW:0] sum;
        sum = {1'b0, base} + (PW+1)'(off);
        if (sum >= (PW+1)'(NREQ)) begin
            sum = sum - (PW+1)'(NREQ);
        end
        return sum[PW-1:0];
    endfunction

    // A unit being granted this cycle is masked so its result is sent once.
    assign w_elig = req & ~grant;

`ifdef CDB_FIXED_PRIO_EN
    assign w_start   = r_ptr;
    assign w_ptr_nxt = '0;
`else
    assign w_start   = r_ptr;
    assign w_ptr_nxt = (w_win == PW'(NREQ-1)) ? '0 : (w_win + PW'(1));
`endif

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_elig[wrap_idx(w_start, k)]) begin
                w_found = 1'b1;
                w_win   = wrap_idx(w_start, k);
            end
        end
    end

    assign w_onehot = NREQ'(1) << w_win;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            grant     <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            r_ptr     <= '0;
        end else if (w_found) begin
            grant     <= w_onehot;
            cdb_valid <= 1'b1;
            cdb_tag   <= req_tag[int'(w_win)*TW +: TW];
            cdb_data  <= req_data[int'(w_win)*DW +: DW];
            r_ptr     <= w_ptr_nxt;
        end else begin
            // Tag and data hold; consumers ignore them while cdb_valid is low.
            grant     <= '0;
            cdb_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire
